// File: rtl/tipi_latch_bank.sv
// tipi_latch_bank: clocked bank of CHANNELS x WIDTH mailbox registers loaded
// from a shared asynchronous TI-side data bus. Each channel has an asynchronous
// latch-enable strobe that is synchronised and captured on its rising edge.
// A pending flag tells the consumer that new data has landed; ack clears it.
// Optional feature macro: TIPI_LATCH_BANK_OVERRUN_EN (sticky overrun flags).
// Bit ordering: bit 0 is the MSB / leftmost on every vector; channel 0 owns
// dout[0:WIDTH-1].
// SYNC_STAGES legal range is 2..4.
module tipi_latch_bank #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned CHANNELS    = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [0:CHANNELS-1]         le,
  input  logic [0:WIDTH-1]            din,
  input  logic [0:CHANNELS-1]         ack,
  output logic [0:CHANNELS*WIDTH-1]   dout,
  output logic [0:CHANNELS-1]         pending,
  output logic [0:CHANNELS-1]         overrun
);

  localparam int unsigned LAST = SYNC_STAGES - 1;

  logic [0:CHANNELS-1] le_sync  [SYNC_STAGES];
  logic [0:WIDTH-1]    din_sync [SYNC_STAGES];
  logic [0:CHANNELS-1] le_prev;
  logic [0:CHANNELS-1] rise;

  // Synchronise strobes and data with equal depth; strobes reset high so a
  // level held through reset release is not mistaken for a rising edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
        le_sync[i]  <= '1;
        din_sync[i] <= '0;
      end
      le_prev <= '1;
    end else begin
      le_sync[0]  <= le;
      din_sync[0] <= din;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        le_sync[i]  <= le_sync[i-1];
        din_sync[i] <= din_sync[i-1];
      end
      le_prev <= le_sync[LAST];
    end
  end

  // Rising edge of each synchronised strobe.
  assign rise = le_sync[LAST] & ~le_prev;

  // Capture data and maintain pending; a capture outranks a same-cycle ack.
  always_ff @(posedge clk) begin
    if (reset) begin
      dout    <= '0;
      pending <= '0;
    end else begin
      for (int unsigned c = 0; c < CHANNELS; c++) begin
        if (rise[c]) begin
          dout[c*WIDTH +: WIDTH] <= din_sync[LAST];
          pending[c]             <= 1'b1;
        end else if (ack[c]) begin
          pending[c] <= 1'b0;
        end
      end
    end
  end

`ifdef TIPI_LATCH_BANK_OVERRUN_EN
  // Sticky overrun: a new capture arrived before the previous one was acked.
  always_ff @(posedge clk) begin
    if (reset) begin
      overrun <= '0;
    end else begin
      for (int unsigned c = 0; c < CHANNELS; c++) begin
        if (rise[c] && pending[c] && !ack[c]) begin
          overrun[c] <= 1'b1;
        end
      end
    end
  end
`else
  assign overrun = '0;
`endif

endmodule

// File: tb/tb_tipi_latch_bank.sv
// tb_tipi_latch_bank: directed stimulus for tipi_latch_bank, checked every
// cycle against a history-based model plus hand-computed literal expectations.
module tb_tipi_latch_bank;

  localparam int unsigned W  = 8;
  localparam int unsigned CH = 4;
  localparam int unsigned S  = 2;
  localparam int unsigned DW = CH * W;
  localparam int          HN = 4096;

  logic              clk;
  logic              reset;
  logic [0:CH-1]     le;
  logic [0:W-1]      din;
  logic [0:CH-1]     ack;
  logic [0:DW-1]     dout;
  logic [0:CH-1]     pending;
  logic [0:CH-1]     overrun;

  int vectors;
  int miscompares;

  tipi_latch_bank #(.WIDTH(W), .CHANNELS(CH), .SYNC_STAGES(S)) dut (
    .clk(clk), .reset(reset), .le(le), .din(din), .ack(ack),
    .dout(dout), .pending(pending), .overrun(overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state: per-edge input history; a capture happens S edges after the
  // edge that first sampled the strobe high following a low sample.
  logic [0:CH-1] hle  [0:HN-1];
  logic [0:W-1]  hdin [0:HN-1];
  logic [0:DW-1] m_dout;
  logic [0:CH-1] m_pend;
  logic [0:CH-1] m_ovr;
  int            n;

  initial begin
    n = -1;
    forever begin
      @(posedge clk);
      n = n + 1;
      hle[n]  = le;
      hdin[n] = din;
      if (reset) begin
        // Reset makes the bank behave as if the strobes had been high for the
        // whole synchroniser depth, so only a fresh low-to-high counts.
        for (int k = 0; k <= int'(S); k++) begin
          if (n - k >= 0) begin
            hle[n-k]  = '1;
            hdin[n-k] = '0;
          end
        end
        m_dout = '0;
        m_pend = '0;
        m_ovr  = '0;
      end else begin
        for (int c = 0; c < int'(CH); c++) begin
          logic cur, prv;
          cur = (n - int'(S) >= 0)     ? hle[n-int'(S)][c]     : 1'b1;
          prv = (n - int'(S) - 1 >= 0) ? hle[n-int'(S)-1][c]   : 1'b1;
          if (cur && !prv) begin
`ifdef TIPI_LATCH_BANK_OVERRUN_EN
            if (m_pend[c] && !ack[c]) m_ovr[c] = 1'b1;
`endif
            m_dout[c*W +: W] = hdin[n-int'(S)];
            m_pend[c]        = 1'b1;
          end else if (ack[c]) begin
            m_pend[c] = 1'b0;
          end
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      vectors = vectors + 1;
      if (dout !== m_dout || pending !== m_pend || overrun !== m_ovr) begin
        miscompares = miscompares + 1;
        $display("FAIL model cycle %0d: dout=%h pend=%b ovr=%b required dout=%h pend=%b ovr=%b",
                 n, dout, pending, overrun, m_dout, m_pend, m_ovr);
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors = vectors + 1;
    if (act !== exp) begin
      miscompares = miscompares + 1;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic cyc(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc(2);
    reset = 1'b0;
    cyc(S + 2);
  endtask

  task automatic write(input logic [0:CH-1] m, input logic [0:W-1] d);
    din = d;
    le  = m;
    cyc(3);
    le = '0;
    cyc(S + 1);
  endtask

  logic exp_ovr;

  initial begin
    vectors     = 0;
    miscompares = 0;
`ifdef TIPI_LATCH_BANK_OVERRUN_EN
    exp_ovr = 1'b1;
`else
    exp_ovr = 1'b0;
`endif
    reset = 1'b1;
    le    = '0;
    din   = '0;
    ack   = '0;
    cyc(3);
    check("reset_dout", 64'(dout), 64'h0);
    check("reset_pending", 64'(pending), 64'h0);
    check("reset_overrun", 64'(overrun), 64'h0);

    // Strobe held high through reset release must not capture.
    le  = '1;
    din = 8'h77;
    cyc(2);
    reset = 1'b0;
    cyc(6);
    check("le_high_release_pending", 64'(pending), 64'h0);
    check("le_high_release_dout", 64'(dout), 64'h0);
    le  = '0;
    din = '0;
    cyc(4);

    // Single channel write; capture lands S+1 edges after the rise.
    din = 8'hAA;
    le  = 4'b0100;
    cyc(3);
    le = '0;
    cyc(S);
    check("ch1_write_dout", 64'(dout), 64'h00AA0000);
    check("ch1_write_pending", 64'(pending), 64'(4'b0100));

    // Data holds while din changes with le low; ack clears pending only.
    din = 8'h00;
    cyc(10);
    check("ch1_hold_dout", 64'(dout), 64'h00AA0000);
    ack = 4'b0100;
    cyc(1);
    ack = '0;
    cyc(1);
    check("ch1_ack_pending", 64'(pending), 64'h0);
    check("ch1_ack_dout", 64'(dout), 64'h00AA0000);

    // Ack on a channel with nothing pending is ignored.
    ack = 4'b1000;
    cyc(1);
    ack = '0;
    cyc(1);
    check("stray_ack_pending", 64'(pending), 64'h0);

    // Two channels rising together capture the same value.
    din = 8'h5C;
    le  = 4'b1001;
    cyc(3);
    le = '0;
    cyc(S);
    check("simul_dout", 64'(dout), 64'h5CAA005C);
    check("simul_pending", 64'(pending), 64'(4'b1001));

    // Back-to-back writes without ack: newer data wins, overrun flags it.
    do_reset();
    write(4'b0010, 8'h11);
    write(4'b0010, 8'h22);
    check("ovr_dout", 64'(dout), 64'h00002200);
    check("ovr_pending", 64'(pending), 64'(4'b0010));
    check("ovr_flag", 64'(overrun), 64'({1'b0, 1'b0, exp_ovr, 1'b0}));

    // Second write acked on its own capture cycle: no overrun, still pending.
    do_reset();
    write(4'b0010, 8'h11);
    din = 8'h22;
    le  = 4'b0010;
    cyc(S);
    ack = 4'b0010;
    cyc(1);
    ack = '0;
    le  = '0;
    cyc(2);
    check("ack_race_overrun", 64'(overrun), 64'h0);
    check("ack_race_pending", 64'(pending), 64'(4'b0010));
    check("ack_race_dout", 64'(dout), 64'h00002200);

    // Reset arriving while a strobe is in the synchroniser discards it.
    do_reset();
    din = 8'h3C;
    le  = 4'b1000;
    cyc(1);
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    cyc(S + 3);
    check("midsync_dout", 64'(dout), 64'h0);
    check("midsync_pending", 64'(pending), 64'h0);
    le = '0;
    cyc(4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
